// File: rtl/ws2812_rx.sv
`timescale 1ns/1ps
// ws2812_rx: WS2812 single-wire stream decoder.
// Classifies each high pulse as a 0 or 1 bit by its width and assembles GRB
// words MSB first. It strobes once per pixel, with the pixel's index in the
// frame, and once per frame at the latch gap. Errors go to a sticky flag that
// keeps the first error code.
module ws2812_rx #(
  parameter int THRESH_CYCLES  = 60,
  parameter int MIN_HIGH       = 15,
  parameter int MAX_HIGH       = 120,
  parameter int RESET_CYCLES   = 5000,
  parameter int BITS_PER_PIXEL = 24,
  parameter int PX_COUNT_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      din,
  input  logic                      clear_err,
  output logic [BITS_PER_PIXEL-1:0] pixel_out,
  output logic                      pixel_valid,
  output logic [PX_COUNT_WIDTH-1:0] pixel_idx,
  output logic                      frame_done,
  output logic [PX_COUNT_WIDTH-1:0] frame_px_count,
  output logic                      err,
  output logic [1:0]                err_code
);

  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int BW = $clog2(BITS_PER_PIXEL + 1);

  localparam logic [HW-1:0]             HIGH_MAX = HW'(MAX_HIGH);
  localparam logic [HW-1:0]             HIGH_MIN = HW'(MIN_HIGH);
  localparam logic [HW-1:0]             HIGH_THR = HW'(THRESH_CYCLES);
  localparam logic [LW-1:0]             LOW_MAX  = LW'(RESET_CYCLES);
  localparam logic [BW-1:0]             LAST_BIT = BW'(BITS_PER_PIXEL - 1);
  localparam logic [PX_COUNT_WIDTH-1:0] IDX_MAX  = '1;

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_PULSE   = 2'b01,
    ERR_PARTIAL = 2'b10,
    ERR_OVF     = 2'b11
  } err_code_t;

  logic din_meta, din_s, din_d;
  logic rise, fall;

  state_t state_q, state_d;

  logic [HW-1:0]             high_cnt;
  logic [LW-1:0]             low_cnt;
  logic [BW-1:0]             bit_cnt;
  // The last bit of a word arrives straight from the classifier, so only
  // BITS_PER_PIXEL-1 bits need storage.
  logic [BITS_PER_PIXEL-2:0] shreg;
  logic [PX_COUNT_WIDTH-1:0] px_idx;
  logic                      px_ovf;

  logic      bad_pulse, take_bit, latch;
  logic      bit_val, word_done, overflow, partial, new_err;
  err_code_t new_code;

  // Two-flop synchronizer on the async line plus one delayed copy for edges.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
      din_d    <= 1'b0;
    end else begin
      din_meta <= din;
      din_s    <= din_meta;
      din_d    <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SYNC;
    else          state_q <= state_d;
  end

  // Next-state logic and per-cycle event decodes.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bad_pulse = 1'b0;
    take_bit  = 1'b0;
    latch     = 1'b0;
    case (state_q)
      SYNC: if (low_cnt == LOW_MAX) state_d = IDLE;
      IDLE: if (rise) state_d = HIGH;
      HIGH: begin
        if (high_cnt == HIGH_MAX) begin
          bad_pulse = 1'b1;
          state_d   = SYNC;
        end else if (fall) begin
          if (high_cnt < HIGH_MIN) begin
            bad_pulse = 1'b1;
            state_d   = SYNC;
          end else begin
            take_bit = 1'b1;
            state_d  = LOW;
          end
        end
      end
      LOW: begin
        if (low_cnt == LOW_MAX) begin
          latch   = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          state_d = HIGH;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign bit_val   = (high_cnt >= HIGH_THR);
  assign word_done = take_bit && (bit_cnt == LAST_BIT);
  assign overflow  = word_done && (px_idx == IDX_MAX);
  assign partial   = latch && (bit_cnt != '0);
  assign new_err   = bad_pulse | partial | overflow;

  // Code of an error raised this cycle (the sources are mutually exclusive).
  always_comb begin
    new_code = ERR_NONE;
    if (bad_pulse)    new_code = ERR_PULSE;
    else if (partial) new_code = ERR_PARTIAL;
    else if (overflow) new_code = ERR_OVF;
  end

  // Pulse-width and gap counters; both saturate at their limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      if (state_d == HIGH && state_q != HIGH) high_cnt <= HW'(1);
      else if (state_q == HIGH && high_cnt != HIGH_MAX) high_cnt <= high_cnt + HW'(1);

      if (take_bit)                  low_cnt <= LW'(1);
      else if (state_q == SYNC)      low_cnt <= din_s ? '0 : (low_cnt == LOW_MAX ? LOW_MAX : low_cnt + LW'(1));
      else if (state_q == LOW)       low_cnt <= (low_cnt == LOW_MAX) ? LOW_MAX : low_cnt + LW'(1);
      else                           low_cnt <= '0;
    end
  end

  // Bit assembly, pixel strobes, frame index bookkeeping and frame strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg          <= '0;
      bit_cnt        <= '0;
      px_idx         <= '0;
      px_ovf         <= 1'b0;
      pixel_out      <= '0;
      pixel_valid    <= 1'b0;
      pixel_idx      <= '0;
      frame_done     <= 1'b0;
      frame_px_count <= '0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (take_bit) shreg <= {shreg[BITS_PER_PIXEL-3:0], bit_val};

      if (state_q == IDLE || latch) begin
        bit_cnt <= '0;
        px_idx  <= '0;
        px_ovf  <= 1'b0;
      end else if (word_done) begin
        bit_cnt     <= '0;
        pixel_valid <= 1'b1;
        pixel_out   <= {shreg, bit_val};
        pixel_idx   <= px_idx;
        // The last index is reused rather than wrapping back to 0.
        if (px_idx == IDX_MAX) px_ovf <= 1'b1;
        else                   px_idx <= px_idx + PX_COUNT_WIDTH'(1);
      end else if (take_bit) begin
        bit_cnt <= bit_cnt + BW'(1);
      end

      if (latch) begin
        frame_done     <= 1'b1;
        frame_px_count <= px_ovf ? IDX_MAX : px_idx;
      end
    end
  end

  // Sticky error flag; the first code is kept, and a new error beats clear_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (new_err) begin
      err <= 1'b1;
      if (!err || clear_err) err_code <= new_code;
    end else if (clear_err) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
`timescale 1ns/1ps
// tb_ws2812_rx: directed stimulus with a scoreboard for the WS2812 decoder.
// The stimulus pushes the expected pixels and frame counts into queues, and a
// monitor process pops one entry each time the DUT raises a strobe.
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        din = 1'b0;
  logic        clear_err = 1'b0;
  logic [23:0] pixel_out;
  logic        pixel_valid;
  logic [5:0]  pixel_idx;
  logic        frame_done;
  logic [5:0]  frame_px_count;
  logic        err;
  logic [1:0]  err_code;

  ws2812_rx dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .din            (din),
    .clear_err      (clear_err),
    .pixel_out      (pixel_out),
    .pixel_valid    (pixel_valid),
    .pixel_idx      (pixel_idx),
    .frame_done     (frame_done),
    .frame_px_count (frame_px_count),
    .err            (err),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic [5:0]  idx;
  } px_t;

  px_t exp_px[$];
  int  exp_fr[$];
  px_t mon_px;
  int  mon_fr;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pixel_out"}, 32'(pixel_out), 32'h0);
    check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'h0);
    check({tag, "_pixel_idx"}, 32'(pixel_idx), 32'h0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    check({tag, "_frame_px_count"}, 32'(frame_px_count), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_err_code"}, 32'(err_code), 32'h0);
  endtask

  // Monitor: every strobe is matched against the head of its queue.
  always @(negedge clk) begin
    if (reset_n && pixel_valid) begin
      if (exp_px.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pixel: got data 0x%06h idx %0d, expected no strobe", pixel_out, pixel_idx);
      end else begin
        mon_px = exp_px.pop_front();
        check("pixel_data", 32'(pixel_out), 32'(mon_px.data));
        check("pixel_idx", 32'(pixel_idx), 32'(mon_px.idx));
      end
    end
    if (reset_n && frame_done) begin
      if (exp_fr.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_frame: got count %0d, expected no strobe", frame_px_count);
      end else begin
        mon_fr = exp_fr.pop_front();
        check("frame_px_count", 32'(frame_px_count), 32'(mon_fr));
      end
    end
  end

  task automatic expect_px(input logic [23:0] d, input int i);
    px_t e;
    e.data = d;
    e.idx  = 6'(i);
    exp_px.push_back(e);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One high pulse of 'high' cycles followed by 'low' cycles; starts and ends on a negedge.
  task automatic pulse(input int high, input int low);
    din = 1'b1;
    repeat (high) @(negedge clk);
    din = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] word, input int nbits,
                           input int t0h, input int t0l, input int t1h, input int t1l);
    for (int b = 23; b > 23 - nbits; b--) begin
      if (word[b]) pulse(t1h, t1l);
      else         pulse(t0h, t0l);
    end
  endtask

  task automatic send_fast(input logic [23:0] word, input int nbits);
    send_bits(word, nbits, 16, 2, 62, 2);
  endtask

  function automatic logic [23:0] word_a(input int i);
    logic [21:0] one_hot;
    one_hot = 22'(1) << (i % 22);
    return {2'(i / 22), one_hot};
  endfunction

  function automatic logic [23:0] word_b(input int i);
    return (i >= 60) ? (24'hC00000 | 24'(i)) : 24'h000000;
  endfunction

  initial begin
    // Reset state.
    @(negedge clk);
    check_cleared("reset");
    reset_n = 1'b1;
    gap(5010);

    // Single pixel with nominal WS2812 timing.
    expect_px(24'hA53C0F, 0);
    send_bits(24'hA53C0F, 24, 40, 85, 80, 45);
    exp_fr.push_back(1);
    gap(5010);
    check("err_after_single_pixel", 32'(err), 32'h0);

    // 52-pixel frame; pixel 0 uses 59-cycle zeros and 60-cycle ones.
    expect_px(24'hAAAAAA, 0);
    send_bits(24'hAAAAAA, 24, 59, 2, 60, 2);
    for (int i = 1; i < 52; i++) begin
      expect_px(word_a(i), i);
      send_fast(word_a(i), 24);
    end
    exp_fr.push_back(52);
    gap(5010);
    check("err_after_full_frame", 32'(err), 32'h0);

    // 65-pixel frame: restarts at idx 0, then the index saturates at 63.
    for (int i = 0; i < 65; i++) begin
      expect_px(word_b(i), (i > 63) ? 63 : i);
      send_fast(word_b(i), 24);
    end
    exp_fr.push_back(63);
    gap(5010);
    check("overflow_err", 32'(err), 32'h1);
    check("overflow_err_code", 32'(err_code), 32'h3);

    // 14-cycle glitch with clear_err in the cycle the bad fall is seen.
    din = 1'b1;
    repeat (14) @(negedge clk);
    din = 1'b0;
    repeat (2) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("glitch_err", 32'(err), 32'h1);
    check("glitch_err_code_new_wins", 32'(err_code), 32'h1);
    gap(5010);

    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("clear_err_err", 32'(err), 32'h0);
    check("clear_err_code", 32'(err_code), 32'h0);

    // Decodes again after the error (zeros at the 15-cycle minimum), then a 120-cycle pulse.
    expect_px(24'h123456, 0);
    send_bits(24'h123456, 24, 15, 2, 60, 2);
    pulse(120, 10);
    check("long_pulse_err", 32'(err), 32'h1);
    check("long_pulse_err_code", 32'(err_code), 32'h1);

    // Reset in the middle of a high pulse, released while the stream is still running.
    send_fast(24'h000000, 10);
    din = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_cleared("mid_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    din = 1'b0;
    repeat (2) @(negedge clk);
    send_fast(24'hFFFFFF, 24);
    gap(5010);
    check("err_after_resync", 32'(err), 32'h0);

    // A full pixel, then 12 bits of a second pixel before the latch.
    expect_px(24'h5A5A5A, 0);
    send_fast(24'h5A5A5A, 24);
    send_fast(24'h000000, 12);
    exp_fr.push_back(1);
    gap(5010);
    check("partial_err", 32'(err), 32'h1);
    check("partial_err_code", 32'(err_code), 32'h2);

    repeat (5) @(negedge clk);
    check("pixels_outstanding", 32'(exp_px.size()), 32'h0);
    check("frames_outstanding", 32'(exp_fr.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
